// File: rtl/systolic_feed_sched.sv
// Skewed feed scheduler for the systolic array: lane i is read i ticks after lane 0,
// the whole wavefront is stalled on any empty due FIFO, then a fixed drain precedes done.
module systolic_feed_sched #(
    parameter int LANES     = 8,
    parameter int KW        = 8,
    parameter int DRAIN_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KW-1:0]    k_len,
    input  logic [LANES-1:0] aemptys,
    input  logic [LANES-1:0] wemptys,
    output logic [LANES-1:0] a_rd,
    output logic [LANES-1:0] w_rd,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int TW = KW + 4;
    localparam int DW = $clog2(DRAIN_CYC) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    t_q, t_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [KW-1:0]    k_q, k_d;
    logic [LANES-1:0] due;
    logic [TW-1:0]    k_ext;
    logic             last_tick;

    assign k_ext     = TW'(k_q);
    assign last_tick = (t_q == k_ext + TW'(LANES - 2));

    // A lane is due while 0 <= t - i < k; the subtraction is only taken once t >= i.
    always_comb begin
        due = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (state_q == S_FEED && t_q >= TW'(i) && (t_q - TW'(i)) < k_ext) begin
                due[i] = 1'b1;
            end
        end
        stall = |(due & (aemptys | wemptys));
        a_rd  = stall ? '0 : due;
    end

    assign w_rd = a_rd;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        drain_d = drain_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        k_d     = k_len;
                        t_d     = '0;
                        state_d = S_FEED;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FEED: begin
                if (!stall) begin
                    t_d = t_q + 1'b1;
                    if (last_tick) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DW'(DRAIN_CYC - 1)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            drain_q <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            drain_q <= drain_d;
            k_q     <= k_d;
        end
    end

endmodule

// File: tb/tb_systolic_feed_sched.sv
// Directed bench for systolic_feed_sched: basic, stall, non-due empty, zero length,
// ignored start, mid-tile reset and maximum-length tiles.
module tb_systolic_feed_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] k_len;
    logic [7:0] aemptys;
    logic [7:0] wemptys;
    logic [7:0] a_rd;
    logic [7:0] w_rd;
    logic       busy;
    logic       stall;
    logic       done;

    int checks = 0;
    int errors = 0;

    systolic_feed_sched #(.LANES(8), .KW(8), .DRAIN_CYC(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .k_len   (k_len),
        .aemptys (aemptys),
        .wemptys (wemptys),
        .a_rd    (a_rd),
        .w_rd    (w_rd),
        .busy    (busy),
        .stall   (stall),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one tile; stl_* injects wemptys[3] at bench tick stl_tick for stl_n cycles,
    // ae7_until holds aemptys[7] while tick < ae7_until, restart_cyc pulses start in FEED.
    task automatic run_tile(input int k, input int exp_feed, input int stl_tick, input int stl_n,
                            input int ae7_until, input int restart_cyc);
        int tt = 0;
        int feed = 0;
        int stalled = 0;
        int cnt_a[8];
        int cnt_w[8];
        logic exp_st;
        logic [7:0] exp_rd;
        for (int i = 0; i < 8; i++) begin
            cnt_a[i] = 0;
            cnt_w[i] = 0;
        end
        wemptys = 8'h00;
        aemptys = (ae7_until > 0) ? 8'h80 : 8'h00;
        start = 1'b1;
        k_len = 8'(k);
        step();
        start = 1'b0;
        k_len = 8'hAA;
        chk("feed_busy", busy, 1'b1);
        while (tt <= k + 6 && feed < 600) begin
            exp_st  = (tt == stl_tick) && (stalled < stl_n);
            wemptys = exp_st ? 8'h08 : 8'h00;
            aemptys = (tt < ae7_until) ? 8'h80 : 8'h00;
            if (feed == restart_cyc) begin
                start = 1'b1;
                k_len = 8'd9;
            end
            #1;
            exp_rd = '0;
            for (int i = 0; i < 8; i++) begin
                if (!exp_st && tt >= i && tt <= i + k - 1) exp_rd[i] = 1'b1;
            end
            chk("feed_a_rd", a_rd, exp_rd);
            chk("feed_w_rd", w_rd, exp_rd);
            chk("feed_stall", stall, exp_st);
            for (int i = 0; i < 8; i++) begin
                cnt_a[i] += int'(a_rd[i]);
                cnt_w[i] += int'(w_rd[i]);
            end
            step();
            start = 1'b0;
            feed++;
            if (exp_st) stalled++;
            else tt++;
        end
        wemptys = 8'h00;
        aemptys = 8'h00;
        chk("feed_len", feed, exp_feed);
        for (int i = 0; i < 8; i++) begin
            chk("lane_a_cnt", cnt_a[i], k);
            chk("lane_w_cnt", cnt_w[i], k);
        end
        for (int d = 0; d < 16; d++) begin
            #1;
            chk("drain_rd", a_rd, 8'h00);
            chk("drain_busy_done", {busy, done}, 2'b10);
            step();
        end
        chk("done_pulse", {busy, done}, 2'b11);
        step();
        chk("back_idle", {busy, done}, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        k_len = 8'd0;
        aemptys = 8'h00;
        wemptys = 8'h00;
        #1;
        chk("rst_outs", {a_rd, w_rd, busy, stall, done}, 19'h0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("idle_outs", {a_rd, busy, stall, done}, 11'h0);

        // basic tile
        run_tile(4, 11, -1, 0, 0, -1);
        // global stall on lane 3 for 2 cycles at tick 4
        run_tile(4, 13, 4, 2, 0, -1);
        // lane 7 empty before it is due
        run_tile(2, 9, -1, 0, 6, -1);

        // zero length
        start = 1'b1;
        k_len = 8'd0;
        step();
        start = 1'b0;
        #1;
        chk("zero_done", {busy, done}, 2'b11);
        chk("zero_rd", a_rd, 8'h00);
        step();
        chk("zero_idle", {busy, done}, 2'b00);

        // start pulsed during FEED with k_len=9 is ignored
        run_tile(2, 9, -1, 0, 0, 2);

        // reset at tick 5 of a k_len=8 tile
        start = 1'b1;
        k_len = 8'd8;
        step();
        start = 1'b0;
        for (int c = 0; c < 5; c++) step();
        #1;
        chk("pre_rst_rd", a_rd, 8'h3F);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {a_rd, w_rd, busy, stall, done}, 19'h0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_idle", {busy, done}, 2'b00);
        run_tile(3, 10, -1, 0, 0, -1);

        // maximum length
        run_tile(255, 262, -1, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
